// File: rtl/gray_code_tx.sv
// gray_code_tx
//   Binary-to-Gray transmitter feeding a Gray decoder, an external pin or a
//   CDC path where single-bit-change codes are required.
//   Convert mode (mode=0): accepts binary words on a valid/ready input and
//   presents them Gray-coded one cycle later.
//   Count mode (mode=1): emits gray(cnt) from an internal up/down counter.
//   Output is a single registered valid/ready slot.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   en         block enable; 0 = nothing new accepted or generated
//   mode       0 = convert, 1 = count
//   dir        count direction, 0 = up, 1 = down
//   load       load internal counter from load_val (priority over advance)
//   load_val   counter load value (binary)
//   in_valid   upstream word valid (convert mode)
//   in_data    upstream binary word
//   in_ready   block can take in_data this cycle (combinational)
//   out_valid  out_gray holds a word not yet accepted
//   out_gray   Gray-coded output word
//   out_ready  downstream accepts out_gray this cycle
//   wrap       one-cycle pulse after the counter wraps
module gray_code_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  input  logic             out_ready,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic             slot_free;
  logic             accept;
  logic             advance;
  logic             wrap_next;

  function automatic logic [WIDTH-1:0] gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // The output register can take a new word if it is empty or is being
  // drained this very cycle.
  assign slot_free = !out_valid || out_ready;

  // in_ready is the only combinational input-to-output path; it is forced
  // low during reset so nothing is handshaken while the block is cleared.
  assign in_ready  = !rst && !mode && en && slot_free;
  assign accept    = in_valid && in_ready;

  // Load takes priority over advance: the cycle spent loading emits nothing.
  assign advance   = mode && en && slot_free && !load;

  // Wrap is decided on the pre-update counter value, so the registered pulse
  // appears in the cycle after the counter rolls over.
  assign wrap_next = advance && (dir ? (cnt == '0) : (cnt == '1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_gray  <= '0;
      cnt       <= '0;
      wrap      <= 1'b0;
    end else begin
      // Output slot: a held word (valid && !ready) is never overwritten
      // because accept/advance both require slot_free.
      if (accept) begin
        out_gray  <= gray(in_data);
        out_valid <= 1'b1;
      end else if (advance) begin
        out_gray  <= gray(cnt);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (load) begin
        cnt <= load_val;
      end else if (advance) begin
        cnt <= dir ? (cnt - CNT_ONE) : (cnt + CNT_ONE);
      end

      wrap <= wrap_next;
    end
  end

endmodule
